// File: rtl/stream_mux2_rr.sv
// stream_mux2_rr
//   Merges two valid/ready input streams (B, C) onto one registered output
//   stream (A). When both inputs offer a word in the same cycle, the grant
//   alternates between them (round robin). Each output word carries a
//   source tag so a downstream 1-to-2 demultiplexer can route it back.
//
// Ports
//   clk, rst              : clock; synchronous active-high reset
//   inB, inB_valid/ready  : input line B (tag 0)
//   inC, inC_valid/ready  : input line C (tag 1)
//   A_out, Select_out     : registered output word and its source tag
//   out_valid, out_ready  : output handshake
//   cntB, cntC            : wrapping counts of words accepted per line
module stream_mux2_rr #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inB,
  input  logic             inB_valid,
  output logic             inB_ready,
  input  logic [WIDTH-1:0] inC,
  input  logic             inC_valid,
  output logic             inC_ready,
  output logic [WIDTH-1:0] A_out,
  output logic             Select_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cntB,
  output logic [CNT_W-1:0] cntC
);

  logic [WIDTH-1:0] data_p0;
  logic             sel_p0;
  logic             vld_p0;
  logic             last_sel;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;

  logic             load;
  logic             grant_b;
  logic             grant_c;

  // Plain modulo increment: the counters wrap rather than saturate.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return v + 1'b1;
  endfunction

  // Input side: arbitration and handshake (combinational)
  always_comb begin
    load      = 1'b0;
    grant_b   = 1'b0;
    grant_c   = 1'b0;
    inB_ready = 1'b0;
    inC_ready = 1'b0;
    // The output register can refill in the same cycle it drains.
    load    = !rst && (!vld_p0 || out_ready);
    // last_sel names the previous winner; on a tie the other line goes.
    grant_b = inB_valid && (!inC_valid || last_sel);
    grant_c = inC_valid && (!inB_valid || !last_sel);
    inB_ready = load && grant_b;
    inC_ready = load && grant_c;
  end

  // Output stage p0: registered word, tag, valid and per-line counters
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0  <= '0;
      sel_p0   <= 1'b0;
      vld_p0   <= 1'b0;
      last_sel <= 1'b1;
      cnt_b    <= '0;
      cnt_c    <= '0;
    end else if (load) begin
      if (inB_ready) begin
        data_p0  <= inB;
        sel_p0   <= 1'b0;
        vld_p0   <= 1'b1;
        last_sel <= 1'b0;
        cnt_b    <= cnt_inc(cnt_b);
      end else if (inC_ready) begin
        data_p0  <= inC;
        sel_p0   <= 1'b1;
        vld_p0   <= 1'b1;
        last_sel <= 1'b1;
        cnt_c    <= cnt_inc(cnt_c);
      end else begin
        // Nothing offered: empty the register, data/tag become don't-care.
        vld_p0 <= 1'b0;
      end
    end
  end

  assign A_out      = data_p0;
  assign Select_out = sel_p0;
  assign out_valid  = vld_p0;
  assign cntB       = cnt_b;
  assign cntC       = cnt_c;

endmodule
